// File: rtl/mux2_pkg.sv
// Shared types and defaults for the mux2_reg datapath selector.
//   MUX2_DEFAULT_WIDTH : default data width
//   mux2_sel_e         : select encoding (SEL_D0 picks d0, SEL_D1 picks d1)
package mux2_pkg;

  localparam int unsigned MUX2_DEFAULT_WIDTH = 1;

  typedef enum logic {
    SEL_D0 = 1'b0,
    SEL_D1 = 1'b1
  } mux2_sel_e;

endpackage

// File: rtl/mux2_reg_if.sv
// Bus bundle for mux2_reg.
//   master : drives d0, d1, s, en; observes y, y_q, s_q, sel_chg (and par_q)
//   slave  : the selector side, the mirror image of master
// Optional macro MUX2_REG_PARITY_EN adds par_q.
interface mux2_reg_if
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             s_q;
  logic             sel_chg;
`ifdef MUX2_REG_PARITY_EN
  logic             par_q;

  modport master (output d0, d1, s, en, input y, y_q, s_q, sel_chg, par_q);
  modport slave  (input d0, d1, s, en, output y, y_q, s_q, sel_chg, par_q);
`else
  modport master (output d0, d1, s, en, input y, y_q, s_q, sel_chg);
  modport slave  (input d0, d1, s, en, output y, y_q, s_q, sel_chg);
`endif

endinterface

// File: rtl/mux2_core.sv
// Purely combinational WIDTH-bit 2:1 selector.
//   i_d0, i_d1 : data inputs
//   i_s        : select (SEL_D1 picks i_d1)
//   o_y_c      : selected data, zero latency
module mux2_core
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  mux2_sel_e        i_s,
  output logic [WIDTH-1:0] o_y_c
);

  assign o_y_c = (i_s == SEL_D1) ? i_d1 : i_d0;

endmodule

// File: rtl/mux2_reg.sv
// 2:1 data selector with a registered pipeline copy and select-change flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : d0, d1, s, en in; y (combinational), y_q, s_q, sel_chg out
// Optional macro MUX2_REG_PARITY_EN adds registered even parity bus.par_q.
module mux2_reg
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  mux2_reg_if.slave bus
);

  logic [WIDTH-1:0] w_mux;
  mux2_sel_e        w_sel;
  logic [WIDTH-1:0] r_y_q;
  mux2_sel_e        r_s_q;
  logic             r_sel_chg;

  assign w_sel = mux2_sel_e'(bus.s);

  // Single selector instance feeds both the live output and the register stage.
  mux2_core #(.WIDTH(WIDTH)) u_core (
    .i_d0  (bus.d0),
    .i_d1  (bus.d1),
    .i_s   (w_sel),
    .o_y_c (w_mux)
  );

  // Register stage; sel_chg compares against the select captured on the previous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q     <= '0;
      r_s_q     <= SEL_D0;
      r_sel_chg <= 1'b0;
    end else if (bus.en) begin
      r_y_q     <= w_mux;
      r_s_q     <= w_sel;
      r_sel_chg <= (w_sel != r_s_q);
    end else begin
      r_sel_chg <= 1'b0;
    end
  end

`ifdef MUX2_REG_PARITY_EN
  logic r_par_q;

  // Parity tracks y_q: loaded with the same enable, so it always describes y_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_q <= 1'b0;
    end else if (bus.en) begin
      r_par_q <= ^w_mux;
    end
  end

  assign bus.par_q = r_par_q;
`endif

  assign bus.y       = w_mux;
  assign bus.y_q     = r_y_q;
  assign bus.s_q     = logic'(r_s_q);
  assign bus.sel_chg = r_sel_chg;

endmodule

// File: tb/tb_mux2_reg.sv
// Self-checking bench for mux2_reg: WIDTH=8 main instance plus a WIDTH=1 instance
// for the pure-combinational check. Expected register values are pushed to a
// scoreboard queue when stimulus is driven and popped after the clock edge.
module tb_mux2_reg;

  logic clk;
  logic rst_n;

  mux2_reg_if #(.WIDTH(8)) bus8 ();
  mux2_reg_if #(.WIDTH(1)) bus1 ();

  mux2_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mux2_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y_q;
    logic       s_q;
    logic       sel_chg;
    logic       par_q;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Reference state of the register stage.
  logic [7:0] m_yq;
  logic       m_sq;
  logic       m_chg;
  logic       m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_yq  = 8'h00;
    m_sq  = 1'b0;
    m_chg = 1'b0;
    m_par = 1'b0;
  endtask

  task automatic check_regs(input string tag, input exp_t e);
    check({tag, ".y_q"},     32'(bus8.y_q),     32'(e.y_q));
    check({tag, ".s_q"},     32'(bus8.s_q),     32'(e.s_q));
    check({tag, ".sel_chg"}, 32'(bus8.sel_chg), 32'(e.sel_chg));
`ifdef MUX2_REG_PARITY_EN
    check({tag, ".par_q"},   32'(bus8.par_q),   32'(e.par_q));
`endif
  endtask

  // One clock cycle: drive at negedge, check y, push expectation, compare after posedge.
  task automatic step(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                      input logic s, input logic en);
    logic [7:0] mux;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    bus8.d0 = d0;
    bus8.d1 = d1;
    bus8.s  = s;
    bus8.en = en;
    mux = s ? d1 : d0;
    #1;
    check({tag, ".y"}, 32'(bus8.y), 32'(mux));
    if (en) begin
      m_chg = (s != m_sq);
      m_yq  = mux;
      m_sq  = s;
      m_par = ^mux;
    end else begin
      m_chg = 1'b0;
    end
    e.y_q = m_yq; e.s_q = m_sq; e.sel_chg = m_chg; e.par_q = m_par;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_regs(tag, got);
    end
  endtask

  exp_t zero_e;

  initial begin
    zero_e.y_q = 8'h00; zero_e.s_q = 1'b0; zero_e.sel_chg = 1'b0; zero_e.par_q = 1'b0;
    rst_n   = 1'b0;
    bus8.d0 = 8'h00; bus8.d1 = 8'h00; bus8.s = 1'b0; bus8.en = 1'b0;
    bus1.d0 = 1'b0;  bus1.d1 = 1'b0;  bus1.s = 1'b0; bus1.en = 1'b0;
    model_reset();
    #2;
    check_regs("reset", zero_e);

    // WIDTH=1 combinational selection, no clock edge in between.
    bus1.d0 = 1'b0; bus1.d1 = 1'b0; bus1.s = 1'b0; #1;
    check("w1.s0_both0", 32'(bus1.y), 32'd0);
    bus1.d1 = 1'b1; #1;
    check("w1.s0_d1hi", 32'(bus1.y), 32'd0);
    bus1.s = 1'b1; #1;
    check("w1.s1_d1hi", 32'(bus1.y), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    // Load d1, then hold the select.
    step("ld_s1",   8'hA5, 8'h3C, 1'b1, 1'b1);
    step("ld_s1b",  8'hA5, 8'h3C, 1'b1, 1'b1);
    step("ld_s0",   8'hA5, 8'h3C, 1'b0, 1'b1);

    // en low: y follows, register stage holds, sel_chg stays low.
    step("hold1",   8'h11, 8'h22, 1'b1, 1'b0);
    step("hold2",   8'h33, 8'h44, 1'b0, 1'b0);
    step("hold3",   8'h55, 8'h66, 1'b1, 1'b0);

    // Equal data, select toggling every cycle.
    step("eq0",     8'hFF, 8'hFF, 1'b1, 1'b1);
    step("eq1",     8'hFF, 8'hFF, 1'b0, 1'b1);
    step("eq2",     8'hFF, 8'hFF, 1'b1, 1'b1);
    step("eq3",     8'hFF, 8'hFF, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with en high: clears before any edge.
    #1;
    bus8.d0 = 8'hA5; bus8.d1 = 8'h3C; bus8.s = 1'b1; bus8.en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_regs("async_rst", zero_e);
    check("async_rst.y", 32'(bus8.y), 32'h3C);
    @(posedge clk);
    #1;
    check_regs("rst_held", zero_e);
    model_reset();
    bus8.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First load after reset compares against s_q = 0.
    step("post_rst1", 8'hA5, 8'h3C, 1'b1, 1'b1);
    step("post_rst2", 8'hA5, 8'h3C, 1'b1, 1'b1);

    // Parity-relevant loads (checked when parity is built).
    step("par07", 8'h07, 8'h00, 1'b0, 1'b1);
    step("par03", 8'h07, 8'h03, 1'b1, 1'b1);
    step("parhold", 8'h01, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
